// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
// SPI mode-0 responder for loopback testing of the SD-card SPI initiator.
// The SPI pins are oversampled in the CLK domain through 2-flop synchronizers.
// Bytes are shifted MSB-first. Received and transmitted bytes are exchanged
// with the core through valid/ready handshakes. A sticky overrun flag records
// received bytes that were dropped because the core had not drained rx_data.
//
// Ports
//   CLK, RST_N          system clock, async active-low reset
//   spi_clk/mosi/cs     SPI pins from the initiator (asynchronous)
//   spi_miso/_en        MISO data and its tri-state enable
//   tx_data/valid/ready byte offered for transmission; tx_ready is a 1-cycle
//                       load strobe and tx_data is sampled only in that cycle
//   rx_data/valid/ready last received byte and its handshake
//   overrun/_clr        sticky dropped-byte flag and its clear
//   busy                synchronized chip select is asserted
//
// State table
//   state  | meaning
//   IDLE   | cs deasserted; sclk edges are ignored
//   ACTIVE | cs asserted; bytes are shifted in and out
// -----------------------------------------------------------------------------
module spi_target #(
    parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs,
    output logic       spi_miso,
    output logic       spi_miso_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic       r_sclk_s1, r_sclk_s2, r_sclk_prev;
    logic       r_mosi_s1, r_mosi_s2, r_mosi_prev;
    logic       r_cs_s1,   r_cs_s2,   r_cs_prev;

    logic [0:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_overrun;
    logic       r_tx_ready;
    logic       r_shift_pend;
    logic [7:0] r_tx_shift;

    logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic       w_active;
    logic       w_bit_rise, w_byte_done;
    logic       w_load, w_shift;
    logic [7:0] w_rx_byte;

    // Synchronizers plus one history flop per pin for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sclk_s1   <= 1'b0;
            r_sclk_s2   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_mosi_prev <= 1'b0;
            r_cs_s1     <= 1'b1;
            r_cs_s2     <= 1'b1;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_s1   <= spi_clk;
            r_sclk_s2   <= r_sclk_s1;
            r_sclk_prev <= r_sclk_s2;
            r_mosi_s1   <= spi_mosi;
            r_mosi_s2   <= r_mosi_s1;
            r_mosi_prev <= r_mosi_s2;
            r_cs_s1     <= spi_cs;
            r_cs_s2     <= r_cs_s1;
            r_cs_prev   <= r_cs_s2;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_prev;
    assign w_cs_rise   = r_cs_s2 & ~r_cs_prev;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_prev;
    assign w_active    = (r_state == ST_ACTIVE);

    // A cs rise in the same cycle wins over any sclk edge, so a partial byte
    // is discarded and no load is started on the way out.
    assign w_bit_rise  = w_active & w_sclk_rise & ~w_cs_rise;
    assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
    assign w_load      = (~w_active & w_cs_fall)
                       | (w_active & w_sclk_fall & ~w_cs_rise & (r_bit_cnt == 3'd0));
    assign w_shift     = w_active & w_sclk_fall & ~w_cs_rise & (r_bit_cnt != 3'd0);

    // mosi is taken from the history flop: one cycle older than the sclk
    // edge detect, and mosi has been stable for several CLKs by then.
    assign w_rx_byte   = {r_rx_shift, r_mosi_prev};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else if (!w_active && w_cs_fall) begin
            r_state <= ST_ACTIVE;
        end else if (w_active && w_cs_rise) begin
            r_state <= ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
        end else begin
            if (!w_active || w_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (w_bit_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_bit_rise) begin
                r_rx_shift <= w_rx_byte[6:0];
            end
        end
    end

    // Receive handshake and overrun. A completing byte is accepted if the
    // holding register is empty or being drained in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_byte_done && (!r_rx_valid || rx_ready)) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (w_byte_done && r_rx_valid && !rx_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Transmit path: the load strobe and shift request are registered, and
    // the shift register acts on them one cycle later, so tx_data is sampled
    // exactly in the tx_ready cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_ready   <= 1'b0;
            r_shift_pend <= 1'b0;
            r_tx_shift   <= 8'hFF;
        end else begin
            r_tx_ready   <= w_load;
            r_shift_pend <= w_shift;
            if (r_tx_ready) begin
                r_tx_shift <= tx_valid ? tx_data : DEFAULT_TX;
            end else if (r_shift_pend) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
            end
        end
    end

    assign spi_miso    = r_tx_shift[7];
    assign spi_miso_en = ~r_cs_s2;
    assign busy        = ~r_cs_s2;
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign overrun     = r_overrun;

endmodule
